// File: rtl/ps2_device.sv
// PS/2 device-side endpoint.
// Generates the PS/2 clock, shifts device-to-host frames out, receives
// host-to-device command frames and drives the acknowledge bit.
// Both bus lines are open-drain: an *_od output of 0 pulls the line low,
// and 1 releases it.
module ps2_device #(
  parameter int HALF_PERIOD_CYC = 2000,
  parameter int GUARD_CYC       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_od,
  output logic       ps2_dat_od
);

  localparam int TW = (HALF_PERIOD_CYC > 1) ? $clog2(HALF_PERIOD_CYC) : 1;
  localparam logic [TW-1:0] TC_VAL    = TW'(HALF_PERIOD_CYC - 1);
  localparam logic [TW-1:0] GUARD_VAL = TW'(GUARD_CYC);

  typedef enum logic [3:0] {
    IDLE,
    TX_HI,
    TX_LO,
    TX_END,
    INHIBIT,
    RX_LO,
    RX_HI,
    ACK_LO,
    ACK_HI
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [10:0]   shreg, shreg_n;
  logic [7:0]    rx_data_n;
  logic          tx_done_n, tx_abort_n;
  logic          rx_valid_n, rx_perr_n, rx_ferr_n;
  logic          clk_od_n, dat_od_n;

  logic          clk_meta, sclk;
  logic          dat_meta, sdat;
  logic          tc;
  logic          guard_done;

  // Two-stage synchronizers for the raw bus lines; they idle at the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta <= 1'b1;
      sclk     <= 1'b1;
      dat_meta <= 1'b1;
      sdat     <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_i;
      sclk     <= clk_meta;
      dat_meta <= ps2_dat_i;
      sdat     <= dat_meta;
    end
  end

  assign tc         = (timer == TC_VAL);
  assign guard_done = (timer >= GUARD_VAL);

  // Upstream may hand over a byte only when idle and the host is not holding either line low.
  assign tx_ready = !rst && en && (state == IDLE) && sclk && sdat;

  // Next-state, shift register, bit counter and pulse generation.
  always_comb begin
    state_n    = state;
    bitcnt_n   = bitcnt;
    shreg_n    = shreg;
    rx_data_n  = rx_data;
    tx_done_n  = 1'b0;
    tx_abort_n = 1'b0;
    rx_valid_n = 1'b0;
    rx_perr_n  = 1'b0;
    rx_ferr_n  = 1'b0;

    case (state)
      IDLE: begin
        if (!sclk) begin
          state_n = INHIBIT;
        end else if (tx_valid && tx_ready) begin
          shreg_n  = {1'b1, ~^tx_data, tx_data, 1'b0};
          bitcnt_n = 4'd0;
          state_n  = TX_HI;
        end
      end

      TX_HI: begin
        if (guard_done && !sclk) begin
          tx_abort_n = 1'b1;
          state_n    = INHIBIT;
        end else if (tc) begin
          state_n = TX_LO;
        end
      end

      TX_LO: begin
        if (tc) begin
          shreg_n  = {1'b1, shreg[10:1]};
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt == 4'd10) begin
            state_n = TX_END;
          end else begin
            state_n = TX_HI;
          end
        end
      end

      TX_END: begin
        if (tc) begin
          tx_done_n = 1'b1;
          state_n   = IDLE;
        end
      end

      INHIBIT: begin
        if (sclk) begin
          if (!sdat) begin
            bitcnt_n = 4'd0;
            state_n  = RX_LO;
          end else begin
            state_n = IDLE;
          end
        end
      end

      RX_LO: begin
        if (tc) begin
          state_n = RX_HI;
        end
      end

      RX_HI: begin
        if (guard_done && !sclk) begin
          state_n = INHIBIT;
        end else if (tc) begin
          shreg_n  = {sdat, shreg[10:1]};
          bitcnt_n = bitcnt + 4'd1;
          if (bitcnt == 4'd9) begin
            if (sdat) begin
              state_n = ACK_LO;
            end else begin
              rx_valid_n = 1'b1;
              rx_data_n  = shreg_n[8:1];
              rx_perr_n  = ~^shreg_n[9:1];
              rx_ferr_n  = 1'b1;
              state_n    = IDLE;
            end
          end else begin
            state_n = RX_LO;
          end
        end
      end

      ACK_LO: begin
        if (tc) begin
          state_n = ACK_HI;
        end
      end

      ACK_HI: begin
        if (tc) begin
          rx_valid_n = 1'b1;
          rx_data_n  = shreg[8:1];
          rx_perr_n  = ~^shreg[9:1];
          state_n    = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (!en) begin
      state_n    = IDLE;
      rx_data_n  = rx_data;
      tx_done_n  = 1'b0;
      tx_abort_n = 1'b0;
      rx_valid_n = 1'b0;
      rx_perr_n  = 1'b0;
      rx_ferr_n  = 1'b0;
    end
  end

  // Half-period timer restarts on every phase change; line drives follow the next state.
  always_comb begin
    if ((state_n != state) || tc) begin
      timer_n = '0;
    end else begin
      timer_n = timer + TW'(1);
    end

    clk_od_n = !((state_n == TX_LO) || (state_n == RX_LO) || (state_n == ACK_LO));

    case (state_n)
      TX_HI, TX_LO:   dat_od_n = shreg_n[0];
      ACK_LO, ACK_HI: dat_od_n = 1'b0;
      default:        dat_od_n = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      bitcnt     <= 4'd0;
      shreg      <= 11'd0;
      rx_data    <= 8'd0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
      rx_valid   <= 1'b0;
      rx_perr    <= 1'b0;
      rx_ferr    <= 1'b0;
      ps2_clk_od <= 1'b1;
      ps2_dat_od <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      rx_data    <= rx_data_n;
      tx_done    <= tx_done_n;
      tx_abort   <= tx_abort_n;
      rx_valid   <= rx_valid_n;
      rx_perr    <= rx_perr_n;
      rx_ferr    <= rx_ferr_n;
      ps2_clk_od <= clk_od_n;
      ps2_dat_od <= dat_od_n;
    end
  end

endmodule
